mux4_rr_scheduler: RTL and testbench

MUX4_RR_SCHEDULER -- requirements
Module: mux4_rr_scheduler

---
 rtl/mux4_rr_scheduler.sv | 139 +++++++++++++
 tb/tb_mux4_rr_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler
//   Round-robin scheduler that gives one of four requesters the shared 4:1
//   mux path. A grant lasts for up to BURST accepted beats. It ends earlier if
//   the grantee drops its request. There is always one IDLE cycle between two
//   grants.
//
//   Handshake: a beat moves when out_valid and out_ready are both high in the
//   same cycle. out_valid does not depend on out_ready. While out_ready is low
//   the grant, the select and the beat count all hold.
//
// Parameters
//   W      width of a, b, c, d and y
//   BURST  maximum accepted beats per grant (legal 1..15)
// Ports
//   clk        clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   req[i] high while requester i wants the path
//   a,b,c,d    data of requesters 0..3
//   out_ready  consumer accepts y this cycle
//   gnt[3:0]   registered one-hot grant, zero when no grant is held
//   s1,s2      registered select, {s1,s2} = current or most recent grantee
//   y          combinational mux of a/b/c/d by {s1,s2}
//   out_valid  y carries a valid beat
//   busy       FSM is in GRANT (also serves as the visible FSM state)
module mux4_rr_scheduler #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s2,
  output logic [W-1:0] y,
  output logic         out_valid,
  output logic         busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] BC_LAST = 4'(BURST - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] lp_q, lp_d;
  logic [3:0] bc_q, bc_d;

  logic [1:0] pick;
  logic       pick_found;
  logic [1:0] cand;

  // Round-robin search. Start at lp+1 and wrap. The last candidate is lp
  // itself (k=4 wraps to offset 0).
  always_comb begin
    pick       = 2'd0;
    pick_found = 1'b0;
    cand       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = lp_q + 2'(k);
      if (!pick_found && req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    lp_d    = lp_q;
    bc_d    = bc_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          bc_d    = 4'd0;
        end
      end
      GRANT: begin
        // A dropped request ends the grant at once and counts no beat.
        // The select register keeps the grantee after release.
        if (!req[sel_q] || (out_ready && bc_q == BC_LAST)) begin
          state_d = IDLE;
          gnt_d   = 4'd0;
          bc_d    = 4'd0;
          lp_d    = sel_q;
        end else if (out_ready) begin
          bc_d = bc_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      lp_q    <= 2'd3;   // requester 0 gets first priority after reset
      bc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      lp_q    <= lp_d;
      bc_q    <= bc_d;
    end
  end

  assign gnt       = gnt_q;
  assign s1        = sel_q[1];
  assign s2        = sel_q[0];
  assign busy      = (state_q == GRANT);
  assign out_valid = (state_q == GRANT) && req[sel_q];

  always_comb begin
    unique case (sel_q)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
module tb_mux4_rr_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] dat[4];
  logic [W-1:0] a, b, c, d;
  logic         out_ready;

  logic [3:0]   gnt, gnt1;
  logic         s1, s2, s1_1, s2_1;
  logic [W-1:0] y, y1;
  logic         out_valid, ov1, busy, busy1;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  assign a = dat[0];
  assign b = dat[1];
  assign c = dat[2];
  assign d = dat[3];

  mux4_rr_scheduler #(.W(W), .BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt), .s1(s1), .s2(s2), .y(y),
    .out_valid(out_valid), .busy(busy)
  );

  mux4_rr_scheduler #(.W(W), .BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt1), .s1(s1_1), .s2(s2_1), .y(y1),
    .out_valid(ov1), .busy(busy1)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Scoreboard: every accepted beat of the main instance must match the head
  // of the expected queue (grantee index and data).
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_beat: got beat sel=%0d y=%h, expected no beat", {s1, s2}, y);
      end else begin
        e = exp_q.pop_front();
        if ({s1, s2, y} !== e) begin
          errors++;
          $display("FAIL sb_beat: got sel=%0d y=%h, expected sel=%0d y=%h",
                   {s1, s2}, y, e[W+1:W], e[W-1:0]);
        end
      end
    end
    if (rst_n === 1'b1) begin
      checks++;
      if (((gnt != 4'd0) !== busy) || ($countones(gnt) > 1)) begin
        errors++;
        $display("FAIL gnt_busy: got gnt=%b busy=%b, expected one-hot gnt iff busy", gnt, busy);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_dat();
    for (int i = 0; i < 4; i++) dat[i] = W'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    rand_dat();
    @(negedge clk);
    checks++;
    if (gnt !== 4'd0 || {s1, s2} !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 || y !== dat[0]) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b sel=%0d busy=%b ov=%b y=%h, expected 0000/0/0/0/%h",
               gnt, {s1, s2}, busy, out_valid, y, dat[0]);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b gnt=%b, expected 0/0000 while reset held", busy, gnt);
    end
    req = 4'b0000;
    rst_n = 1'b1;
  endtask

  // Reset priority and rotation: grants 0,1,2,3,0 with 4 beats each and one
  // idle cycle between. The BURST=1 instance alternates idle/grant, 0,1,2,...
  task automatic test_rotation();
    int k, ph, g, g1;
    for (int t = 0; t < 25; t++) begin
      k = t / 5; ph = t % 5; g = k % 4;
      cyc();
      req = 4'b1111; out_ready = 1'b1;
      rand_dat();
      if (t == 1) dat[0] = 8'h11;
      if (ph != 0) exp_q.push_back({2'(g), dat[g]});
      @(negedge clk);
      checks++;
      if (ph == 0) begin
        if (busy !== 1'b0 || gnt !== 4'd0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rot_idle t=%0d: got busy=%b gnt=%b ov=%b, expected 0/0000/0", t, busy, gnt, out_valid);
        end
        if (k > 0) begin
          checks++;
          if ({s1, s2} !== 2'((k - 1) % 4) || y !== dat[(k - 1) % 4]) begin
            errors++;
            $display("FAIL rot_idle_sel t=%0d: got sel=%0d y=%h, expected sel=%0d y=%h",
                     t, {s1, s2}, y, (k - 1) % 4, dat[(k - 1) % 4]);
          end
        end
      end else begin
        if (gnt !== (4'b0001 << g) || {s1, s2} !== 2'(g) || out_valid !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rot_grant t=%0d: got gnt=%b sel=%0d ov=%b busy=%b, expected %b/%0d/1/1",
                   t, gnt, {s1, s2}, out_valid, busy, 4'b0001 << g, g);
        end
        if (t == 1) begin
          checks++;
          if (y !== 8'h11) begin
            errors++;
            $display("FAIL first_y: got y=%h, expected 11", y);
          end
        end
      end
      checks++;
      g1 = ((t - 1) / 2) % 4;
      if (t % 2 == 0) begin
        if (busy1 !== 1'b0 || gnt1 !== 4'd0) begin
          errors++;
          $display("FAIL burst1_idle t=%0d: got busy=%b gnt=%b, expected 0/0000", t, busy1, gnt1);
        end
      end else if (busy1 !== 1'b1 || gnt1 !== (4'b0001 << g1) || ov1 !== 1'b1 || y1 !== dat[g1]) begin
        errors++;
        $display("FAIL burst1_grant t=%0d: got busy=%b gnt=%b ov=%b y=%h, expected 1/%b/1/%h",
                 t, busy1, gnt1, ov1, y1, 4'b0001 << g1, dat[g1]);
      end
    end
    cyc();
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {s1, s2} !== 2'd0) begin
      errors++;
      $display("FAIL rot_end: got busy=%b sel=%0d, expected 0/0", busy, {s1, s2});
    end
  endtask

  task automatic test_early_drop();
    cyc();
    req = 4'b0100; out_ready = 1'b1; rand_dat(); dat[2] = 8'hC3;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      cyc();
      exp_q.push_back({2'd2, 8'hC3});
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || out_valid !== 1'b1 || y !== 8'hC3) begin
        errors++;
        $display("FAIL drop_grant: got gnt=%b ov=%b y=%h, expected 0100/1/c3", gnt, out_valid, y);
      end
    end
    cyc();
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_cycle: got ov=%b busy=%b, expected 0/1", out_valid, busy);
    end
    cyc();
    req = 4'b1001; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== 4'd0 || {s1, s2} !== 2'd2) begin
      errors++;
      $display("FAIL drop_release: got busy=%b gnt=%b sel=%0d, expected 0/0000/2", busy, gnt, {s1, s2});
    end
    cyc();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000 || {s1, s2} !== 2'd3) begin
      errors++;
      $display("FAIL drop_next: got gnt=%b sel=%0d, expected 1000/3", gnt, {s1, s2});
    end
    cyc();
    req = 4'b0000;
    @(negedge clk);
    cyc();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_next_release: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bv;
    bv = W'($urandom_range(0, 255));
    cyc();
    req = 4'b0010; out_ready = 1'b0; rand_dat(); dat[1] = bv;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      cyc();
      out_ready = 1'b0; rand_dat(); dat[1] = bv;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || gnt !== 4'b0010 || y !== bv || {s1, s2} !== 2'd1) begin
        errors++;
        $display("FAIL bp_stall n=%0d: got ov=%b gnt=%b y=%h sel=%0d, expected 1/0010/%h/1",
                 n, out_valid, gnt, y, {s1, s2}, bv);
      end
    end
    for (int n = 0; n < 4; n++) begin
      cyc();
      out_ready = 1'b1;
      exp_q.push_back({2'd1, bv});
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_beat n=%0d: got gnt=%b busy=%b, expected 0010/1", n, gnt, busy);
      end
    end
    cyc();
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== 4'd0) begin
      errors++;
      $display("FAIL bp_release: got busy=%b gnt=%b, expected 0/0000", busy, gnt);
    end
  endtask

  task automatic test_no_preempt();
    cyc();
    req = 4'b1000; out_ready = 1'b1; rand_dat();
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      cyc();
      req = (n == 1) ? 4'b1001 : 4'b1000;
      rand_dat();
      exp_q.push_back({2'd3, dat[3]});
      @(negedge clk);
      checks++;
      if (gnt !== 4'b1000 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL nopre n=%0d: got gnt=%b ov=%b, expected 1000/1", n, gnt, out_valid);
      end
    end
    cyc();
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL nopre_release: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    req = 4'b0100; out_ready = 1'b0; rand_dat();
    @(negedge clk);
    cyc();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_grant: got gnt=%b busy=%b, expected 0100/1", gnt, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'd0 || {s1, s2} !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got gnt=%b sel=%0d ov=%b busy=%b, expected 0000/0/0/0",
               gnt, {s1, s2}, out_valid, busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    req = 4'b0101;
    @(negedge clk);
    cyc();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || {s1, s2} !== 2'd0) begin
      errors++;
      $display("FAIL rmid_regrant: got gnt=%b sel=%0d, expected 0001/0", gnt, {s1, s2});
    end
    cyc();
    req = 4'b0000;
    @(negedge clk);
    cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    rand_dat();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rotation();
    test_early_drop();
    test_backpressure();
    test_no_preempt();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d beats still expected, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
